// File: rtl/pipe_excp_ctrl_pkg.sv
// Shared constants for the OpenMIPS pipeline sequencer: exception codes, stall masks,
// CP0 Status/Cause bit positions and the controller state encoding.
package pipe_excp_ctrl_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INTR    = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000A;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000C;
    localparam logic [31:0] EXC_OV      = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_BEV   = 22;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;

    localparam logic [31:0] BEV_EXC_VEC = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    // Synchronous exception codes the MEM stage may raise; anything else is ignored.
    function automatic logic is_sync_excp(input logic [31:0] code);
        return (code == EXC_SYSCALL) || (code == EXC_INVALID) || (code == EXC_TRAP) ||
               (code == EXC_OV) || (code == EXC_ERET);
    endfunction

endpackage

// File: rtl/pipe_excp_ctrl_stall_enc.sv
// Priority encoder turning per-stage stall requests into the 6-bit pipeline stall vector.
// The oldest requesting stage wins because it freezes everything upstream of it.
module pipe_stall_enc
    import pipe_excp_ctrl_pkg::*;
(
    input  logic       stallreq_id_i,
    input  logic       stallreq_ex_i,
    input  logic       stallreq_mem_i,
    output logic [5:0] stall_o
);

    always_comb begin
        stall_o = STALL_NONE;
        if (stallreq_mem_i) begin
            stall_o = STALL_MEM;
        end else if (stallreq_ex_i) begin
            stall_o = STALL_EX;
        end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
        end
    end

endmodule

// File: rtl/pipe_excp_ctrl.sv
// Exception/interrupt sequencer: commits one exception to CP0, then pulses a flush with redirect PC.
// Optional macro PIPE_EXCP_CTRL_BEV_EN selects the bootstrap vector when Status.BEV is set.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal flow; arbitration of interrupts vs MEM exceptions
// ST_FLUSH | one-cycle flush pulse, new_pc_o carries the redirect target
// ST_GUARD | exceptions masked until the guard counter expires
module pipe_excp_ctrl
    import pipe_excp_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC      = 32'h0000_0020,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excp_type_i,
    input  logic        inst_valid_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] excp_type_o,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  guard_cnt_q, guard_cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic        intr_pend;
    logic [31:0] arb_code;
    logic [31:0] target;
    logic [5:0]  enc_stall;
    logic        unused_cp0;

    pipe_stall_enc u_stall_enc (
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .stall_o        (enc_stall)
    );

    assign intr_pend = cp0_status_i[STATUS_IE] & ~cp0_status_i[STATUS_EXL] &
                       (|(cp0_cause_i[CAUSE_IP_HI:CAUSE_IP_LO] &
                          cp0_status_i[STATUS_IM_HI:STATUS_IM_LO]));

    assign unused_cp0 = ^{cp0_status_i, cp0_cause_i};

    // An interrupt is only taken against a real instruction so EPC points somewhere meaningful.
    always_comb begin
        arb_code = EXC_NONE;
        if (intr_pend && inst_valid_i) begin
            arb_code = EXC_INTR;
        end else if (is_sync_excp(excp_type_i)) begin
            arb_code = excp_type_i;
        end
    end

    always_comb begin
        target = EXC_VEC;
        if (arb_code == EXC_ERET) begin
            target = cp0_epc_i;
        end
`ifdef PIPE_EXCP_CTRL_BEV_EN
        else if (cp0_status_i[STATUS_BEV]) begin
            target = BEV_EXC_VEC;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        flush_d     = 1'b0;
        new_pc_d    = new_pc_q;
        excp_type_o = EXC_NONE;
        stall_o     = enc_stall;

        case (state_q)
            ST_RUN: begin
                if (arb_code != EXC_NONE) begin
                    excp_type_o = arb_code;
                    stall_o     = STALL_ALL;
                    new_pc_d    = target;
                    flush_d     = 1'b1;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                stall_o     = STALL_NONE;
                guard_cnt_d = GUARD_LOAD;
                state_d     = ST_GUARD;
            end
            ST_GUARD: begin
                // A frozen MEM stage must not let the guard window run out.
                if (!enc_stall[4]) begin
                    if (guard_cnt_q == 4'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        guard_cnt_d = guard_cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!rst_n) begin
            excp_type_o = EXC_NONE;
            stall_o     = STALL_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            guard_cnt_q <= 4'd0;
            flush_q     <= 1'b0;
            new_pc_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
        end
    end

    assign flush_o  = flush_q;
    assign new_pc_o = new_pc_q;

endmodule

// File: tb/tb_pipe_excp_ctrl.sv
// Bench for pipe_excp_ctrl: directed vector table, reset-in-flush sequence and a randomized
// run against a cycle-level behavioural model.
module tb_pipe_excp_ctrl;

`ifdef PIPE_EXCP_CTRL_BEV_EN
    localparam bit          BEV_EN  = 1'b1;
    localparam logic [31:0] BEV_TGT = 32'hBFC0_0380;
`else
    localparam bit          BEV_EN  = 1'b0;
    localparam logic [31:0] BEV_TGT = 32'h0000_0020;
`endif
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic [31:0] excp_type_i;
    logic        inst_valid_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic [31:0] excp_type_o;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_excp_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .excp_type_i    (excp_type_i),
        .inst_valid_i   (inst_valid_i),
        .cp0_status_i   (cp0_status_i),
        .cp0_cause_i    (cp0_cause_i),
        .cp0_epc_i      (cp0_epc_i),
        .excp_type_o    (excp_type_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o)
    );

    typedef struct {
        logic        id, ex, mem;
        logic [31:0] excp;
        logic        valid;
        logic [31:0] status, cause, epc;
        logic [31:0] e_excp;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic id, input logic ex, input logic mem, input logic [31:0] excp,
                         input logic valid, input logic [31:0] status, input logic [31:0] cause,
                         input logic [31:0] epc);
        stallreq_id_i  = id;
        stallreq_ex_i  = ex;
        stallreq_mem_i = mem;
        excp_type_i    = excp;
        inst_valid_i   = valid;
        cp0_status_i   = status;
        cp0_cause_i    = cause;
        cp0_epc_i      = epc;
    endtask

    task automatic add(input logic id, input logic ex, input logic mem, input logic [31:0] excp,
                       input logic valid, input logic [31:0] status, input logic [31:0] cause,
                       input logic [31:0] epc, input logic [31:0] e_excp, input logic [5:0] e_stall,
                       input logic e_flush, input logic [31:0] e_pc);
        vec_t v;
        v.id = id; v.ex = ex; v.mem = mem; v.excp = excp; v.valid = valid;
        v.status = status; v.cause = cause; v.epc = epc;
        v.e_excp = e_excp; v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    // Behavioural model: a pending flush, a count of unstalled guard cycles left, and the target.
    bit          m_pending;
    int          m_guard_left;
    logic [31:0] m_pc;

    function automatic logic [5:0] m_enc(input logic id, input logic ex, input logic mem);
        if (mem) return 6'b011111;
        if (ex)  return 6'b001111;
        if (id)  return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic [31:0] m_arb(input logic [31:0] code, input logic valid,
                                          input logic [31:0] status, input logic [31:0] cause);
        logic [7:0] hits;
        hits = cause[15:8] & status[15:8];
        if (status[0] && !status[1] && hits != 8'h00 && valid) return 32'h1;
        if (code == 32'h8 || code == 32'hA || code == 32'hC || code == 32'hD || code == 32'hE)
            return code;
        return 32'h0;
    endfunction

    initial begin
        logic [31:0] codes [11];
        logic [31:0] e_excp, code;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] st, ca;

        codes = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h3, 32'h8, 32'hA, 32'hC, 32'hD, 32'hE};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_stall", 32'(stall_o), 32'h0);
            chk("reset_flush", 32'(flush_o), 32'h0);
            chk("reset_excp", excp_type_o, 32'h0);
            chk("reset_newpc", new_pc_o, 32'h0);
        end
        @(posedge clk); #1;

        //  id ex mem excp   v  status        cause         epc           e_excp  e_stall e_fl e_pc
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h0);
        add(1, 0, 1, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h1F, 0, 32'h0);
        add(1, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h07, 0, 32'h0);
        add(0, 0, 0, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h8, 6'h3F, 0, 32'h0);
        add(0, 0, 0, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 1, 32'h20);
        add(0, 0, 0, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'hD, 1, 32'h401,      32'h400,      32'h0,        32'h1, 6'h3F, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 1, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'hD, 1, 32'h403,      32'h400,      32'h0,        32'hD, 6'h3F, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 1, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'hE, 1, 32'h0,        32'h0,        32'h1234,     32'hE, 6'h3F, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 1, 32'h1234);
        add(0, 0, 1, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h0, 6'h1F, 0, 32'h1234);
        add(0, 0, 0, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h1234);
        add(0, 0, 0, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h1234);
        add(0, 0, 0, 32'h8, 1, 32'h0,        32'h0,        32'h0,        32'h8, 6'h3F, 0, 32'h1234);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 1, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 1, 0, 32'h3, 1, 32'h0,        32'h0,        32'h0,        32'h0, 6'h0F, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h401,      32'h400,      32'h0,        32'h0, 6'h00, 0, 32'h20);
        add(0, 0, 0, 32'h8, 1, 32'h0040_0000, 32'h0,       32'h0,        32'h8, 6'h3F, 0, 32'h20);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 1, BEV_TGT);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, BEV_TGT);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 0, BEV_TGT);
        add(0, 0, 0, 32'hE, 1, 32'h0040_0000, 32'h0,       32'h5678,     32'hE, 6'h3F, 0, BEV_TGT);
        add(0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        32'h0,        32'h0, 6'h00, 1, 32'h5678);

        foreach (vecs[i]) begin
            drive(vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].excp, vecs[i].valid,
                  vecs[i].status, vecs[i].cause, vecs[i].epc);
            @(negedge clk);
            chk($sformatf("vec%0d_excp", i), excp_type_o, vecs[i].e_excp);
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_o), 32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_newpc", i), new_pc_o, vecs[i].e_pc);
            @(posedge clk); #1;
        end

        // Reset asserted during the flush cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        drive(0, 0, 0, 32'h8, 1, 0, 0, 0);
        @(negedge clk);
        chk("rstflush_commit", excp_type_o, 32'h8);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstflush_pulse", 32'(flush_o), 32'h1);
        rst_n = 1'b0;
        drive(1, 0, 1, 32'h8, 1, 32'h401, 32'h400, 0);
        #1;
        chk("rstflush_flush_drop", 32'(flush_o), 32'h0);
        chk("rstflush_newpc_clr", new_pc_o, 32'h0);
        chk("rstflush_excp_zero", excp_type_o, 32'h0);
        chk("rstflush_stall_zero", 32'(stall_o), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_flush", 32'(flush_o), 32'h0);
            chk("postrst_newpc", new_pc_o, 32'h0);
        end
        @(posedge clk); #1;

        // Randomized run against the model, starting from the post-reset state.
        m_pending    = 1'b0;
        m_guard_left = 0;
        m_pc         = 32'h0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            st = $urandom;
            st[0]  = ($urandom_range(0, 3) != 0);
            st[1]  = ($urandom_range(0, 3) == 0);
            st[22] = BEV_EN ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
            ca = $urandom;
            if ($urandom_range(0, 2) != 0) ca[15:8] = 8'h00;
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  codes[$urandom_range(0, 10)], 1'($urandom_range(0, 1)), st, ca, $urandom);

            code = m_arb(excp_type_i, inst_valid_i, cp0_status_i, cp0_cause_i);
            if (m_pending) begin
                e_excp = 32'h0; e_stall = 6'h00; e_flush = 1'b1;
            end else if (m_guard_left > 0 || code == 32'h0) begin
                e_excp = 32'h0; e_flush = 1'b0;
                e_stall = m_enc(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
            end else begin
                e_excp = code; e_stall = 6'h3F; e_flush = 1'b0;
            end

            @(negedge clk);
            chk("rnd_excp", excp_type_o, e_excp);
            chk("rnd_stall", 32'(stall_o), 32'(e_stall));
            chk("rnd_flush", 32'(flush_o), 32'(e_flush));
            chk("rnd_newpc", new_pc_o, m_pc);

            if (m_pending) begin
                m_pending    = 1'b0;
                m_guard_left = G;
            end else if (m_guard_left > 0) begin
                if (!stallreq_mem_i) m_guard_left--;
            end else if (code != 32'h0) begin
                m_pending = 1'b1;
                if (code == 32'hE)                 m_pc = cp0_epc_i;
                else if (BEV_EN && cp0_status_i[22]) m_pc = 32'hBFC0_0380;
                else                               m_pc = 32'h0000_0020;
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_excp_ctrl.md
Name: pipe_excp_ctrl

Overview:
- Pipeline sequencer for the OpenMIPS core.
- Merges per-stage stall requests into a 6-bit stall vector.
- Detects pending interrupts from CP0 Status/Cause.
- Arbitrates interrupts against the memory-stage exception code, hands the committed exception to CP0, then drives a registered pipeline flush plus redirect PC.
- Sits between the ID/EX/MEM stages, CP0 and the PC/IF stage.

Parameters:
EXC_VEC, 32'h0000_0020, general exception entry address
GUARD_CYCLES, 2, cycles after a flush during which new exceptions/interrupts are masked (1..15)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
stallreq_id_i  input  1  ID stage stall request
stallreq_ex_i  input  1  EX stage stall request
stallreq_mem_i  input  1  MEM stage stall request
excp_type_i  input  32  MEM stage exception code: 0 none, 1 intr, 8 syscall, A invalid, C trap, D ov, E eret
inst_valid_i  input  1  MEM stage holds a real (non-bubble) instruction
cp0_status_i  input  32  CP0 Status (forwarded)
cp0_cause_i  input  32  CP0 Cause (forwarded)
cp0_epc_i  input  32  CP0 EPC (forwarded)
excp_type_o  output  32  committed exception code to CP0
stall_o  output  6  stall vector [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
flush_o  output  1  flush all pipeline registers
new_pc_o  output  32  redirect target, valid while flush_o=1

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=RUN, guard counter=0, flush_o=0, new_pc_o=0. Combinational outputs evaluate to 0 in reset.
- Interrupt pending: intr_pend = Status[0](IE) & ~Status[1](EXL) & |(Cause[15:8] & Status[15:8]).
- Arbitration in RUN, highest priority first:
  1. intr_pend & inst_valid_i -> code 1.
  2. excp_type_i in {8,A,C,D,E} -> that code.
  3. Otherwise none. Any other nonzero code is treated as none.
- FSM states: RUN, FLUSH, GUARD.
- RUN, exception chosen (cycle N):
  - excp_type_o = code (combinational, CP0 commits at end of N).
  - stall_o = 6'b111111.
  - Target registered: cp0_epc_i if code E, else EXC_VEC.
  - Next state FLUSH.
- RUN, no exception: excp_type_o=0; stall_o from the stall encoder.
- FLUSH (cycle N+1): flush_o=1, new_pc_o=target, stall_o=0, excp_type_o=0. Next state GUARD with counter loaded to GUARD_CYCLES-1. If GUARD_CYCLES==1, still one GUARD cycle.
- GUARD:
  - Exceptions and interrupts ignored; excp_type_o=0.
  - Stall encoder active.
  - Counter decrements each cycle; when 0, next state RUN.
  - The counter holds while stall_o[4]=1, so a frozen MEM stage cannot expire the guard.
- Stall encoder:
  - stallreq_mem -> 6'b011111.
  - else stallreq_ex -> 6'b001111.
  - else stallreq_id -> 6'b000111.
  - else 0.
  - The oldest stage wins on simultaneous requests.
- Exception vs stall: an exception in RUN overrides all stall requests for cycle N.
- flush_o is a one-cycle pulse, never asserted two consecutive cycles. new_pc_o keeps its last value when flush_o=0.
- Reset mid-FLUSH or mid-GUARD: immediate return to RUN, no flush pulse emitted afterwards.

Optional Feature:
- Macro: PIPE_EXCP_CTRL_BEV_EN.
- Defined: when Status[22](BEV)=1 and code!=E, target = 32'hBFC0_0380; otherwise EXC_VEC.
- Undefined: BEV ignored; target always EXC_VEC for non-eret codes.

Decomposition:
- Shared package/defines file holds:
  - exception code constants (EXC_NONE/INTR/SYSCALL/INVALID/TRAP/OV/ERET);
  - stall mask constants;
  - Status/Cause bit-index constants (IE, EXL, BEV, IM, IP);
  - FSM state encoding.
- One natural sub-module: pipe_stall_enc (combinational three-request priority encoder to 6-bit stall vector), instanced once.

Test Plan:
- Reset release, all inputs 0 -> stall_o=0, flush_o=0, excp_type_o=0, new_pc_o=0 for 10 cycles.
- stallreq_id_i=1 and stallreq_mem_i=1 together -> stall_o=6'b011111; drop mem -> 6'b000111 next cycle.
- excp_type_i=8, inst_valid_i=1 in RUN -> cycle N: excp_type_o=8, stall_o=6'h3F; N+1: flush_o=1, new_pc_o=32'h20; N+2..N+3 (GUARD_CYCLES=2): repeated excp_type_i=8 ignored, excp_type_o=0.
- Status=32'h0000_0401, Cause=32'h0000_0400, excp_type_i=D, inst_valid_i=1 -> excp_type_o=1 (interrupt wins), new_pc_o=32'h20. Same with Status[1]=1 -> excp_type_o=D.
- excp_type_i=E, cp0_epc_i=32'h0000_1234 -> excp_type_o=E, next cycle flush_o=1, new_pc_o=32'h0000_1234; with BEV=1 and macro defined, eret still targets EPC while syscall targets 32'hBFC0_0380.
- rst_n asserted in the FLUSH cycle -> flush_o drops immediately, state RUN; after release, no flush pulse and new_pc_o=0.
